// File: rtl/sprite_scan_ctrl_pkg.sv
// rtl/sprite_scan_ctrl_pkg.sv - shared scan states, sprite RAM field codes and address helper
package sprite_scan_ctrl_pkg;

    // Scan sequence: one ce_6m tick per fetch/latch state
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FX,
        ST_FY,
        ST_FT,
        ST_LD,
        ST_DONE
    } scan_state_e;

    // Sprite RAM word fields within one sprite entry (field 3 is never scanned)
    localparam logic [1:0] FLD_X = 2'd0;  // X position / palette
    localparam logic [1:0] FLD_Y = 2'd1;  // Y position / line
    localparam logic [1:0] FLD_T = 2'd2;  // tile / flip

    function automatic logic [7:0] scan_addr(input logic [5:0] idx, input logic [1:0] fld);
        return {idx, fld};
    endfunction

endpackage

// File: rtl/sprite_scan_ctrl.sv
// rtl/sprite_scan_ctrl.sv - per-line sprite RAM scan sequencer with inline 68k access arbitration
//
// Ports:
//   clk, reset          system clock, asynchronous active-high reset
//   ce_6m               pixel-rate enable; scan state advances only on these ticks
//   line_start          one-clk pulse at start of horizontal blank
//   cpu_req/we/addr     68k sprite RAM request (held until cpu_ack)
//   spr_addr, wren      sprite RAM address / write enable
//   load                sprite latch strobe, high for the LD tick
//   buf_sel             line buffer ping-pong select, toggles per line_start
//   cpu_ack             one-clk pulse the clk after a granted access
//   busy                high while a line scan is running
module sprite_scan_ctrl
    import sprite_scan_ctrl_pkg::*;
#(
    parameter int NUM_SPR = 64
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ce_6m,
    input  logic       line_start,
    input  logic       cpu_req,
    input  logic       cpu_we,
    input  logic [7:0] cpu_addr,
    output logic [7:0] spr_addr,
    output logic       wren,
    output logic       load,
    output logic       buf_sel,
    output logic       cpu_ack,
    output logic       busy
);

    localparam logic [5:0] LAST_IDX = 6'(NUM_SPR - 1);

    scan_state_e state_q, state_d;
    logic [5:0]  idx_q, idx_d;
    logic [7:0]  spr_addr_q, spr_addr_d;
    logic        wren_q, wren_d;
    logic        load_q, load_d;
    logic        buf_sel_q, buf_sel_d;
    logic        cpu_ack_q, cpu_ack_d;
    logic        busy_q, busy_d;
    logic        gnt_q, gnt_d;      // CPU access presented to RAM this clk
    logic        pend_q, pend_d;    // line_start seen, waiting for the next ce_6m tick
    logic        armed_q, armed_d;  // cpu_req has been low since the last grant

    logic start_go;
    logic scan_idle;
    logic grant;

    always_comb begin
        start_go  = (line_start | pend_q) & ce_6m;
        scan_idle = (state_q == ST_IDLE) || (state_q == ST_DONE);
        // A grant never shares an edge with scan start, so spr_addr has one owner per clk
        grant     = cpu_req & armed_q & scan_idle & ~start_go;

        state_d    = state_q;
        idx_d      = idx_q;
        spr_addr_d = spr_addr_q;
        wren_d     = 1'b0;
        cpu_ack_d  = gnt_q;
        gnt_d      = grant;
        buf_sel_d  = buf_sel_q ^ line_start;
        pend_d     = (line_start | pend_q) & ~ce_6m;
        armed_d    = grant ? 1'b0 : (armed_q | ~cpu_req);

        if (start_go) begin
            // New line (or abort of a running one): restart at sprite 0
            state_d = ST_FX;
            idx_d   = 6'd0;
        end else if (ce_6m) begin
            unique case (state_q)
                ST_FX:   state_d = ST_FY;
                ST_FY:   state_d = ST_FT;
                ST_FT:   state_d = ST_LD;
                ST_LD: begin
                    if (idx_q == LAST_IDX) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_FX;
                        idx_d   = idx_q + 6'd1;
                    end
                end
                default: state_d = state_q;
            endcase
        end

        unique case (state_d)
            ST_FX:   spr_addr_d = scan_addr(idx_d, FLD_X);
            ST_FY:   spr_addr_d = scan_addr(idx_d, FLD_Y);
            ST_FT:   spr_addr_d = scan_addr(idx_d, FLD_T);
            default: spr_addr_d = spr_addr_q;
        endcase

        if (grant) begin
            spr_addr_d = cpu_addr;
            wren_d     = cpu_we;
        end

        load_d = (state_d == ST_LD);
        busy_d = (state_d == ST_FX) || (state_d == ST_FY) ||
                 (state_d == ST_FT) || (state_d == ST_LD);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            idx_q      <= 6'd0;
            spr_addr_q <= 8'd0;
            wren_q     <= 1'b0;
            load_q     <= 1'b0;
            buf_sel_q  <= 1'b0;
            cpu_ack_q  <= 1'b0;
            busy_q     <= 1'b0;
            gnt_q      <= 1'b0;
            pend_q     <= 1'b0;
            armed_q    <= 1'b1;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            spr_addr_q <= spr_addr_d;
            wren_q     <= wren_d;
            load_q     <= load_d;
            buf_sel_q  <= buf_sel_d;
            cpu_ack_q  <= cpu_ack_d;
            busy_q     <= busy_d;
            gnt_q      <= gnt_d;
            pend_q     <= pend_d;
            armed_q    <= armed_d;
        end
    end

    assign spr_addr = spr_addr_q;
    assign wren     = wren_q;
    assign load     = load_q;
    assign buf_sel  = buf_sel_q;
    assign cpu_ack  = cpu_ack_q;
    assign busy     = busy_q;

endmodule

// File: doc/sprite_scan_ctrl.md
SPRITE_SCAN_CTRL -- requirements
Module: sprite_scan_ctrl

Interface
REQ-001 SHALL provide parameter NUM_SPR, default 64, sprites scanned per line (power of 2, 2..64).
REQ-002 SHALL provide port clk  in  1  system clock; all state on its rising edge.
REQ-003 SHALL provide port reset  in  1  asynchronous active-high reset.
REQ-004 SHALL provide port ce_6m  in  1  pixel-rate clock enable; scan FSM advances only when high.
REQ-005 SHALL provide port line_start  in  1  one-clk pulse at start of horizontal blank.
REQ-006 SHALL provide port cpu_req  in  1  68k sprite-RAM access request, held until cpu_ack.
REQ-007 SHALL provide port cpu_we  in  1  request is a write.
REQ-008 SHALL provide port cpu_addr  in  8  68k word address into sprite RAM.
REQ-009 SHALL provide port spr_addr  out  8  sprite RAM address = {sprite index[5:0], field[1:0]}.
REQ-010 SHALL provide port wren  out  1  sprite RAM write enable.
REQ-011 SHALL provide port load  out  1  sprite latch strobe (downstream nLATCH_X = ~(CLK_1_5M & load)).
REQ-012 SHALL provide port buf_sel  out  1  line-buffer ping-pong select (0: even writes/odd reads).
REQ-013 SHALL provide port cpu_ack  out  1  one-clk access-complete pulse.
REQ-014 SHALL provide port busy  out  1  high while a line scan is in progress.

Function
REQ-015 FSM states IDLE, FX, FY, FT, LD, DONE; each scan state lasts exactly one ce_6m tick.
REQ-016 IDLE -> FX on line_start; FX -> FY -> FT -> LD; LD -> FX with index+1, or -> DONE when index = NUM_SPR-1.
REQ-017 DONE -> FX on next line_start; otherwise hold.
REQ-018 Scan drives spr_addr field: FX=2'd0 (X/palette), FY=2'd1 (Y/line), FT=2'd2 (tile/flip); field 2'd3 never scanned.
REQ-019 load SHALL be high for exactly the ce_6m tick in LD, low otherwise.
REQ-020 Full line scan = 4*NUM_SPR ce_6m ticks (256 for default); busy high from FX entry through the last LD tick.
REQ-021 buf_sel SHALL toggle on every line_start, regardless of state.
REQ-022 line_start while busy SHALL abort: index reset to 0, state FX, no load for the aborted sprite.
REQ-023 Arbitration: scan owns RAM while busy; CPU served only in IDLE or DONE.
REQ-024 Granted CPU access: spr_addr = cpu_addr and wren = cpu_we for one clk, cpu_ack pulses the following clk; no re-grant until cpu_req has been low for at least one clk.
REQ-025 line_start coinciding with a CPU grant cycle: CPU cycle completes (ack issued), scan enters FX on the next ce_6m tick.
REQ-026 Index counter 6 bits, no wrap past NUM_SPR-1; wren never asserted by scan.

Reset
REQ-027 On reset: state IDLE, index 0, spr_addr 0, wren 0, load 0, buf_sel 0, cpu_ack 0, busy 0.
REQ-028 Reset asserted mid-scan SHALL abandon the line; first scan after release waits for line_start.

Structure
REQ-029 Shared package SHALL hold the state enum and field codes FLD_X=0, FLD_Y=1, FLD_T=2.
REQ-030 Single module; no sub-modules (CPU arbitration inline).

Verification
REQ-031 Reset, one line_start, ce_6m every 4th clk -> buf_sel=1; spr_addr 0x00,0x01,0x02 then load; 64 load pulses; last spr_addr 0xFE; busy low after tick 256.
REQ-032 cpu_req write addr 0x45 while busy -> no wren until DONE; then wren=1, spr_addr=0x45 one clk, cpu_ack next clk.
REQ-033 Second line_start at tick 100 -> buf_sel toggles, index 0, spr_addr 0x00, 64 full loads follow.
REQ-034 line_start and CPU grant in same clk -> cpu_ack still issued; FX at next ce_6m tick.
REQ-035 Reset pulse at tick 50 -> all outputs 0 immediately; idle until next line_start.
REQ-036 cpu_req held high after ack -> exactly one ack until cpu_req drops and reasserts.
